dual_port_ram: RTL and testbench

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

---
 rtl/dual_port_ram.sv | 107 ++++++++++
 tb/tb_dual_port_ram.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram.sv
// Simple-dual-port RAM (one write port, one registered read port) with a
// sequenced clear engine that fills the array with INIT_VALUE after reset or on request.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | user reads/writes accepted
// CLEAR | one word per cycle set to INIT_VALUE; user ports ignored
module dual_port_ram #(
  parameter int              SIZE        = 8,
  parameter int              addressSIZE = 5,
  parameter int              RDW_MODE    = 0,
  parameter logic [SIZE-1:0] INIT_VALUE  = '0
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   RamInit,
  output logic                   InitBusy,
  input  logic                   WE,
  input  logic [addressSIZE-1:0] WAddress,
  input  logic [SIZE-1:0]        D,
  input  logic                   RE,
  input  logic [addressSIZE-1:0] RAddress,
  output logic [SIZE-1:0]        Q,
  output logic                   QValid
);

  localparam int DEPTH = 1 << addressSIZE;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [addressSIZE-1:0] clr_addr_q, clr_addr_d;
  logic [SIZE-1:0]        q_q, q_d;
  logic                   qvalid_q, qvalid_d;

  logic [SIZE-1:0]        mem_q [DEPTH];
  logic                   mem_we;
  logic [addressSIZE-1:0] mem_waddr;
  logic [SIZE-1:0]        mem_wdata;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    q_d        = q_q;
    qvalid_d   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = WAddress;
    mem_wdata  = D;
    case (state_q)
      IDLE: begin
        if (RamInit) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
        mem_we = WE;
        if (RE) begin
          qvalid_d = 1'b1;
          // Same-address read-during-write: bypass only in new-data builds
          if ((RDW_MODE != 0) && WE && (WAddress == RAddress))
            q_d = D;
          else
            q_d = mem_q[RAddress];
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = INIT_VALUE;
        if (RamInit)
          clr_addr_d = '0;
        else if (&clr_addr_q)
          state_d = IDLE;
        else
          clr_addr_d = clr_addr_q + 1'b1;
      end
      default: begin
        state_d    = CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      q_q        <= '0;
      qvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      q_q        <= q_d;
      qvalid_q   <= qvalid_d;
    end
  end

  // The array itself has no reset; it is initialised by the CLEAR sequence.
  always_ff @(posedge clock) begin
    if (mem_we)
      mem_q[mem_waddr] <= mem_wdata;
  end

  assign InitBusy = (state_q == CLEAR);
  assign Q        = q_q;
  assign QValid   = qvalid_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram (SIZE=8, addressSIZE=5).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_dual_port_ram;

  localparam int RDW = 0;

  logic       clock = 1'b0;
  logic       resetN;
  logic       RamInit;
  logic       InitBusy;
  logic       WE;
  logic [4:0] WAddress;
  logic [7:0] D;
  logic       RE;
  logic [4:0] RAddress;
  logic [7:0] Q;
  logic       QValid;

  int n_vec = 0;
  int n_err = 0;

  dual_port_ram #(
    .SIZE(8), .addressSIZE(5), .RDW_MODE(RDW), .INIT_VALUE(8'h00)
  ) dut (
    .clock(clock), .resetN(resetN), .RamInit(RamInit), .InitBusy(InitBusy),
    .WE(WE), .WAddress(WAddress), .D(D), .RE(RE), .RAddress(RAddress),
    .Q(Q), .QValid(QValid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (InitBusy === 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    WE = 1'b1; WAddress = a; D = d;
    tick();
    WE = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [4:0] a, input logic [7:0] exp);
    RE = 1'b1; RAddress = a;
    tick();
    RE = 1'b0;
    chk({tag, "_qv"}, QValid, 1'b1);
    chk(tag, Q, exp);
  endtask

  initial begin
    int cnt;
    int qv_hits;
    logic q_moved;
    logic [7:0] q_hold;

    resetN = 1'b0; RamInit = 1'b0; WE = 1'b0; RE = 1'b0;
    WAddress = '0; RAddress = '0; D = '0;
    repeat (3) tick();
    chk("rst_q", Q, 8'h00);
    chk("rst_qv", QValid, 1'b0);
    chk("rst_busy", InitBusy, 1'b1);

    resetN = 1'b1;
    wait_idle(cnt);
    chk("rst_clear_len", cnt, 32);

    do_read("rd0", 5'd0, 8'h00);
    do_read("rd17", 5'd17, 8'h00);
    do_read("rd31", 5'd31, 8'h00);

    do_write(5'd3, 8'hA5);
    do_read("rd3", 5'd3, 8'hA5);
    tick();
    chk("re0_qv", QValid, 1'b0);
    chk("re0_q", Q, 8'hA5);

    do_write(5'd7, 8'h11);
    WE = 1'b1; WAddress = 5'd7; D = 8'h22;
    do_read("rdw7", 5'd7, (RDW != 0) ? 8'h22 : 8'h11);
    WE = 1'b0;
    do_read("rdw7_after", 5'd7, 8'h22);

    do_write(5'd31, 8'h5A);
    WE = 1'b1; WAddress = 5'd0; D = 8'h3C;
    do_read("diff_rd31", 5'd31, 8'h5A);
    WE = 1'b0;
    do_read("diff_rd0", 5'd0, 8'h3C);

    // Reset in the middle of a clear sequence
    RamInit = 1'b1;
    tick();
    RamInit = 1'b0;
    chk("clr_start_busy", InitBusy, 1'b1);
    repeat (19) tick();
    resetN = 1'b0;
    #1;
    chk("midrst_q", Q, 8'h00);
    chk("midrst_qv", QValid, 1'b0);
    chk("midrst_busy", InitBusy, 1'b1);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    wait_idle(cnt);
    chk("midrst_clear_len", cnt, 32);

    for (int i = 0; i < 32; i++) do_write(5'(i), 8'hFF);
    do_read("fill_rd9", 5'd9, 8'hFF);

    // Clear restarted after 10 busy cycles, with user traffic throughout
    RamInit = 1'b1;
    tick();
    RamInit = 1'b0;
    WE = 1'b1; RE = 1'b1; D = 8'hFF;
    q_hold = Q;
    q_moved = 1'b0;
    qv_hits = 0;
    cnt = 0;
    while (InitBusy === 1'b1 && cnt < 200) begin
      WAddress = 5'(cnt); RAddress = 5'(cnt + 3);
      if (cnt == 9) RamInit = 1'b1;
      tick();
      RamInit = 1'b0;
      cnt++;
      if (QValid !== 1'b0) qv_hits++;
      if (Q !== q_hold) q_moved = 1'b1;
    end
    WE = 1'b0; RE = 1'b0;
    chk("restart_clear_len", cnt, 42);
    chk("clear_qv_count", qv_hits, 0);
    chk("clear_q_held", q_moved, 1'b0);
    for (int i = 0; i < 32; i++)
      do_read($sformatf("post_clr_rd%0d", i), 5'(i), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
